// File: rtl/sequenciador_de_pc.sv
// Next-address controller for the 26-bit PC: sequential, branch, jump, halt and interrupt/RFI sequencing.
// Optional interrupt support (int_hab, epc, int_ack, vector, rfi) is built only when INTERRUPCAO_EN is defined.
module sequenciador_de_pc #(
  parameter logic [25:0] VETOR_INT      = 26'd1,
  parameter int          LARGURA_OFFSET = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [25:0]               pcAtual,
  input  logic                      espera,
  input  logic                      desvio,
  input  logic [LARGURA_OFFSET-1:0] offset,
  input  logic                      salto,
  input  logic [25:0]               alvo,
  input  logic                      parar,
  input  logic                      retomar,
  input  logic                      int_liga,
  input  logic                      int_desliga,
  input  logic                      irq,
  input  logic                      rfi,
  output logic [25:0]               endereco,
  output logic                      pc_reset,
  output logic [25:0]               epc,
  output logic                      int_ack,
  output logic [1:0]                estado
);

  typedef enum logic [1:0] {
    INICIO  = 2'd0,
    EXECUTA = 2'd1,
    PARADO  = 2'd2
  } estado_t;

  estado_t     r_estado;
  estado_t     w_estadoProx;
  logic [25:0] w_seq;
  logic [25:0] w_offsetExt;
  logic [25:0] w_br;
  logic [25:0] w_enderecoNormal;
  logic [25:0] w_endereco;
  logic [25:0] w_epcAtual;
  logic        w_intOk;
  logic        w_rfiOk;

  assign w_offsetExt = 26'($signed(offset));
  assign w_seq       = pcAtual + 26'd1;
  assign w_br        = w_seq + w_offsetExt;

  // Address chosen when no interrupt is taken in EXECUTA; also the value saved into epc on entry.
  always_comb begin
    w_enderecoNormal = w_seq;
    if (w_rfiOk)
      w_enderecoNormal = w_epcAtual;
    else if (parar)
      w_enderecoNormal = pcAtual;
    else if (salto)
      w_enderecoNormal = alvo;
    else if (desvio)
      w_enderecoNormal = w_br;
  end

  always_comb begin
    w_endereco   = pcAtual;
    w_estadoProx = r_estado;
    case (r_estado)
      INICIO: begin
        w_endereco   = 26'd0;
        w_estadoProx = EXECUTA;
      end
      EXECUTA: begin
        if (espera) begin
          w_endereco = pcAtual;
        end else if (w_intOk) begin
          w_endereco = VETOR_INT;
        end else begin
          w_endereco = w_enderecoNormal;
          if (parar && !w_rfiOk)
            w_estadoProx = PARADO;
        end
      end
      PARADO: begin
        if (w_intOk) begin
          w_endereco   = VETOR_INT;
          w_estadoProx = EXECUTA;
        end else if (retomar) begin
          w_endereco   = w_seq;
          w_estadoProx = EXECUTA;
        end
      end
      default: begin
        w_endereco   = 26'd0;
        w_estadoProx = INICIO;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      r_estado <= INICIO;
    else
      r_estado <= w_estadoProx;
  end

  assign endereco = w_endereco;
  assign pc_reset = (r_estado == INICIO);
  assign estado   = r_estado;

`ifdef INTERRUPCAO_EN
  logic        r_hab;
  logic        r_ack;
  logic [25:0] r_epc;
  logic        w_tomaInt;
  logic        w_rfiTomado;
  logic        w_habProx;
  logic [25:0] w_epcNovo;

  assign w_intOk     = irq & r_hab;
  assign w_rfiOk     = rfi;
  assign w_epcAtual  = r_epc;
  assign w_tomaInt   = w_intOk & (((r_estado == EXECUTA) & ~espera) | (r_estado == PARADO));
  assign w_rfiTomado = rfi & (r_estado == EXECUTA) & ~espera & ~w_intOk;
  assign w_epcNovo   = (r_estado == PARADO) ? w_seq : w_enderecoNormal;

  // Later assignments win: disable beats enable, rfi re-enables, interrupt entry clears last.
  always_comb begin
    w_habProx = r_hab;
    if ((r_estado != INICIO) && !(espera && (r_estado == EXECUTA))) begin
      if (int_desliga)
        w_habProx = 1'b0;
      else if (int_liga)
        w_habProx = 1'b1;
    end
    if (w_rfiTomado)
      w_habProx = 1'b1;
    if (w_tomaInt)
      w_habProx = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_hab <= 1'b0;
      r_ack <= 1'b0;
      r_epc <= 26'd0;
    end else begin
      r_hab <= w_habProx;
      r_ack <= w_tomaInt;
      if (w_tomaInt)
        r_epc <= w_epcNovo;
    end
  end

  assign epc     = r_epc;
  assign int_ack = r_ack;
`else
  // Interrupt inputs are folded into a constant-zero term so the request is never seen.
  assign w_intOk    = irq & rfi & int_liga & int_desliga & 1'b0;
  assign w_rfiOk    = 1'b0;
  assign w_epcAtual = 26'd0;
  assign epc        = 26'd0;
  assign int_ack    = 1'b0;
`endif

endmodule

// File: doc/sequenciador_de_pc.md
# sequenciador_de_pc

Next-address controller for the 26-bit program counter register. Every cycle it selects the address the PC loads: sequential increment, branch, jump, return-from-interrupt or interrupt vector. It drives the PC's synchronous reset, and holds the PC on stalls and halts. It sits between the control unit/branch logic and the PC register, and owns the halt state and the saved interrupt return address (EPC).

## Interface
- VETOR_INT, default 26'd1: interrupt vector address.
- LARGURA_OFFSET, default 16: width of the signed branch offset.

- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- pcAtual  in  26  current PC register value.
- espera  in  1  pipeline/memory stall; hold the PC.
- desvio  in  1  conditional branch taken.
- offset  in  LARGURA_OFFSET  signed branch offset, in words.
- salto  in  1  jump.
- alvo  in  26  jump target.
- parar  in  1  halt instruction at pcAtual.
- retomar  in  1  leave halt.
- int_liga / int_desliga  in  1 each  enable / disable interrupts.
- irq  in  1  level interrupt request.
- rfi  in  1  return from interrupt.
- endereco  out  26  next PC value (combinational), wired to the PC input.
- pc_reset  out  1  PC synchronous reset; 1 iff estado==INICIO.
- epc  out  26  saved return address (registered).
- int_ack  out  1  one-cycle pulse when an interrupt is taken (registered).
- estado  out  2  INICIO=0, EXECUTA=1, PARADO=2.

## Operation
**FSM**
- INICIO → EXECUTA on the first clock edge. The PC loads 0 via pc_reset on that same edge.
- EXECUTA → PARADO on parar, when not stalled and no interrupt is taken.
- PARADO → EXECUTA on retomar, or on an accepted irq.

**Arithmetic**
- seq = pcAtual+1.
- br = pcAtual+1+sign_extend(offset) to 26 bits.
- All sums are mod 2^26; 26'h3FFFFFF+1 wraps to 0.

**EXECUTA address priority (highest first)**
1. espera → pcAtual. No register changes; irq, rfi and parar are ignored this cycle.
2. irq && int_hab → VETOR_INT.
   - epc ← the address that priorities 3–7 would have produced.
   - int_hab ← 0; int_ack ← 1.
3. rfi → epc; int_hab ← 1.
4. parar → pcAtual; go to PARADO.
5. salto → alvo.
6. desvio → br.
7. Otherwise → seq.

**PARADO**
- Default: endereco = pcAtual.
- irq && int_hab: endereco = VETOR_INT, epc ← pcAtual+1, take the interrupt, go to EXECUTA.
- Otherwise retomar: endereco = pcAtual+1, go to EXECUTA.
- espera has no effect in PARADO.

**INICIO**
- endereco = 26'd0.
- All requests ignored.

**Interrupt enable (int_hab, internal)**
- int_liga sets it; int_desliga clears it. Simultaneous int_liga and int_desliga: clear wins.
- Interrupt entry clears it; rfi sets it. Interrupt entry overrides int_liga in the same cycle.
- Both int_liga and int_desliga are ignored while espera is high.

## Timing
**Reset values**
- estado=INICIO, pc_reset=1, epc=0, int_ack=0, int_hab=0.

**Latency and timing**
- endereco is combinational, zero latency. The PC updates on the same edge that commits the FSM/epc update.
- int_ack is high exactly the one cycle after the accepting edge.
- irq is level-sensitive. A still-high irq is re-taken only after int_hab returns to 1.

**Reset mid-operation**
- Asynchronously forces all reset values.
- The PC returns to 0 on the first edge after release.

## Configuration
- INTERRUPCAO_EN defined:
  - interrupt logic as above (int_hab, epc, int_ack, VETOR_INT, rfi).
- INTERRUPCAO_EN undefined:
  - irq, rfi, int_liga and int_desliga are ignored.
  - epc and int_ack are tied to 0; no int_hab or epc registers are built.
  - PARADO exits only on retomar.

## Test plan
- Reset release, no requests, pcAtual tracking endereco: pc_reset=1 for one cycle, then endereco = 1,2,3…; estado 0→1.
- pcAtual=10: desvio with offset=16'hFFFC → endereco=7. Same cycle with salto, alvo=100 → endereco=100. espera also high → endereco=10.
- pcAtual=26'h3FFFFFF with no request → endereco=0 (wrap).
- pcAtual=20 and int_liga set, then irq together with desvio and offset=5:
  - endereco=VETOR_INT, epc=26, int_ack pulses one cycle.
  - rfi two cycles later → endereco=26.
- pcAtual=40, parar → estado=PARADO with endereco=40 held. Then retomar → endereco=41. Repeat with interrupts enabled plus irq → endereco=VETOR_INT, epc=41.
- Build without INTERRUPCAO_EN: irq plus int_liga produce no vector jump; int_ack=0 and epc=0 throughout.
